// File: rtl/gpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mem_pkg
//  Brief    : Shared constants for the CPU/GPU data-memory arbiter: memory
//             geometry, requester IDs, FSM encoding and the GPU buffer map.
//  Revision : 1.0  initial release
// ============================================================================
package gpu_mem_pkg;

  // Memory geometry (64K x 16 single-port data memory)
  localparam int MEM_AW = 16;
  localparam int MEM_DW = 16;

  // Requester identifiers, also used as the round-robin pointer value
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_GPU = 1'b1;

  // Arbiter FSM encoding
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_OPEN   = 1'b0;
  localparam arb_state_t ST_LOCKED = 1'b1;

  // Frame-loader buffer map: two 320-word distance lines, two texture lines,
  // and the single flag word at the top of memory
  localparam logic [MEM_AW-1:0] DISTANCE_1   = 16'hF800;
  localparam logic [MEM_AW-1:0] DISTANCE_2   = 16'hF940;
  localparam logic [MEM_AW-1:0] TEXTURE_1    = 16'hFA80;
  localparam logic [MEM_AW-1:0] TEXTURE_2    = 16'hFBC0;
  localparam logic [MEM_AW-1:0] FLAG_ADDRESS = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/starve_counter.sv
`default_nettype none
// ============================================================================
//  Module   : starve_counter
//  Brief    : Counts consecutive cycles a requester waits without a grant and
//             raises o_forced once the wait reaches MAX_WAIT.
//  Revision : 1.0  initial release
// ============================================================================
module starve_counter #(
  parameter int MAX_WAIT = 8,
  parameter int WW       = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_forced
);

  localparam logic [WW-1:0] CNT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] r_cnt;

  // Saturating wait count; any grant or a dropped request restarts it
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + WW'(1);
    end
  end

  assign o_forced = i_req && (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/gpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpu_mem_arbiter
//  Brief    : Single-port data-memory arbiter between the CPU data port and
//             the GPU frame loader. One access per cycle, GPU priority in
//             vblank, GPU burst lock, and starvation-forced grants.
//  Revision : 1.0  initial release
// ============================================================================
module gpu_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int AW       = MEM_AW,
  parameter int DW       = MEM_DW,
  parameter int MAX_WAIT = 8,
  parameter int LOCK_MAX = 660
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_vblank,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_gpu_req,
  input  logic          i_gpu_we,
  input  logic [AW-1:0] i_gpu_addr,
  input  logic [DW-1:0] i_gpu_wdata,
  input  logic          i_gpu_lock,
  output logic          o_gpu_gnt,
  output logic          o_gpu_rvalid,
  output logic [DW-1:0] o_gpu_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int             LW         = $clog2(LOCK_MAX + 1);
  localparam logic [LW-1:0]  LOCK_MAX_C = LW'(LOCK_MAX);

  arb_state_t    r_state, w_state_nxt;
  logic          r_rr_next, w_rr_nxt;
  logic [LW-1:0] r_lock_cnt, w_lock_cnt_nxt, w_lock_inc;
  logic          r_cpu_rvalid, r_gpu_rvalid;
  logic          w_cpu_forced, w_gpu_forced;
  logic          w_cpu_gnt, w_gpu_gnt;

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_cpu_wait (
    .clk      (clk),
    .clr      (clr),
    .i_req    (i_cpu_req),
    .i_gnt    (w_cpu_gnt),
    .o_forced (w_cpu_forced)
  );

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_gpu_wait (
    .clk      (clk),
    .clr      (clr),
    .i_req    (i_gpu_req),
    .i_gnt    (w_gpu_gnt),
    .o_forced (w_gpu_forced)
  );

  // Grant decision: forced side, then lock, then vblank priority, then round robin
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_gpu_gnt = 1'b0;
    if (w_cpu_forced) begin
      w_cpu_gnt = 1'b1;
    end else if (w_gpu_forced) begin
      w_gpu_gnt = 1'b1;
    end else if (r_state == ST_LOCKED) begin
      w_gpu_gnt = i_gpu_req;
    end else if (i_vblank) begin
      if (i_gpu_req) w_gpu_gnt = 1'b1;
      else           w_cpu_gnt = i_cpu_req;
    end else if (r_rr_next == REQ_CPU) begin
      if (i_cpu_req) w_cpu_gnt = 1'b1;
      else           w_gpu_gnt = i_gpu_req;
    end else begin
      if (i_gpu_req) w_gpu_gnt = 1'b1;
      else           w_cpu_gnt = i_cpu_req;
    end
  end

  // Memory port mux; idle port is driven to zero
  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    if (w_cpu_gnt) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_we    = i_cpu_we;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_gpu_gnt) begin
      o_mem_addr  = i_gpu_addr;
      o_mem_we    = i_gpu_we;
      o_mem_wdata = i_gpu_wdata;
    end
  end

  assign w_lock_inc = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt : r_lock_cnt + LW'(1);

  // Next state: lock entry/exit, lock length count and round-robin pointer
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_rr_nxt       = r_rr_next;
    if (w_cpu_gnt)      w_rr_nxt = REQ_GPU;
    else if (w_gpu_gnt) w_rr_nxt = REQ_CPU;
    case (r_state)
      ST_OPEN: begin
        if (w_gpu_gnt && i_gpu_lock) begin
          w_state_nxt    = ST_LOCKED;
          w_lock_cnt_nxt = LW'(1);
        end
      end
      ST_LOCKED: begin
        if (w_gpu_gnt) w_lock_cnt_nxt = w_lock_inc;
        // The grant that brings the count to LOCK_MAX is the last of the burst
        if (w_cpu_gnt || !i_gpu_lock) begin
          w_state_nxt    = ST_OPEN;
          w_lock_cnt_nxt = '0;
        end else if (w_lock_cnt_nxt == LOCK_MAX_C) begin
          w_state_nxt    = ST_OPEN;
          w_lock_cnt_nxt = '0;
          w_rr_nxt       = REQ_CPU;
        end
      end
      default: begin
        w_state_nxt    = ST_OPEN;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // State, round-robin pointer, lock count and read-valid registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state      <= ST_OPEN;
      r_rr_next    <= REQ_CPU;
      r_lock_cnt   <= '0;
      r_cpu_rvalid <= 1'b0;
      r_gpu_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_next    <= w_rr_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_cpu_rvalid <= w_cpu_gnt && !i_cpu_we;
      r_gpu_rvalid <= w_gpu_gnt && !i_gpu_we;
    end
  end

  assign o_cpu_gnt    = w_cpu_gnt;
  assign o_gpu_gnt    = w_gpu_gnt;
  assign o_cpu_rvalid = r_cpu_rvalid;
  assign o_gpu_rvalid = r_gpu_rvalid;
  assign o_cpu_rdata  = i_mem_rdata;
  assign o_gpu_rdata  = i_mem_rdata;

endmodule
`default_nettype wire
